// File: rtl/adxl_spi_if.sv
// 4-wire SPI bus between the G-sensor master and the ADXL345 responder.
interface adxl_spi_if;
    logic spi_clk;
    logic spi_csn;
    logic spi_sdi;
    logic spi_sdo;
    logic spi_sdo_oe;

    modport master (output spi_clk, spi_csn, spi_sdi, input spi_sdo, spi_sdo_oe);
    modport slave  (input spi_clk, spi_csn, spi_sdi, output spi_sdo, spi_sdo_oe);
endinterface

// File: rtl/adxl_spi_responder.sv
// ADXL345 SPI (mode 3) register-subset responder for board-level simulation.
// Define ADXL_INT_EN to enable the DATA_READY flag and INT1/INT2 outputs.
module adxl_spi_responder #(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter logic [7:0] BW_RATE_RST = 8'h0A
) (
    input  logic        clk,
    input  logic        rst,
    adxl_spi_if.slave   spi,
    input  logic [15:0] data_x,
    input  logic [15:0] data_y,
    input  logic [15:0] data_z,
    input  logic        sample_valid,
    output logic        wr_strobe,
    output logic [5:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic [1:0]  interrupt
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]  sclk_sync, csn_sync, sdi_sync;
    logic        sclk_q, csn_q;
    logic        sclk_rise, sclk_fall, csn_rise, csn_fall;
    logic [1:0]  state;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_in, shift_out, byte_in, rd_byte, int_source;
    logic [5:0]  addr, addr_next, rd_addr;
    logic        rnw, mb, sdo, byte_done, wr_ok;
    logic [7:0]  bw_rate, power_ctl, int_enable, int_map, data_format;
    logic [15:0] shad_x, shad_y, shad_z;

    // CSN chain resets low so a select already held low across reset is not
    // mistaken for a fresh fall; a real fall needs a high level seen first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= 2'b11;
            sclk_q    <= 1'b1;
            csn_sync  <= 2'b00;
            csn_q     <= 1'b0;
            sdi_sync  <= 2'b00;
        end else begin
            sclk_sync <= {sclk_sync[0], spi.spi_clk};
            sclk_q    <= sclk_sync[1];
            csn_sync  <= {csn_sync[0], spi.spi_csn};
            csn_q     <= csn_sync[1];
            sdi_sync  <= {sdi_sync[0], spi.spi_sdi};
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_q;
    assign sclk_fall = ~sclk_sync[1] & sclk_q;
    assign csn_rise  = csn_sync[1] & ~csn_q;
    assign csn_fall  = ~csn_sync[1] & csn_q;
    assign byte_in   = {shift_in[6:0], sdi_sync[1]};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7);
    assign addr_next = mb ? addr + 6'd1 : addr;

`ifdef ADXL_INT_EN
    logic       dr_flag, rd_hit;
    logic [1:0] irq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dr_flag <= 1'b0;
            rd_hit  <= 1'b0;
            irq     <= 2'b00;
        end else begin
            if (csn_fall)
                rd_hit <= 1'b0;
            else if (!csn_rise && byte_done && state == S_DATA && rnw &&
                     addr >= 6'h32 && addr <= 6'h37)
                rd_hit <= 1'b1;
            if (sample_valid)
                dr_flag <= 1'b1;
            else if (csn_rise && rd_hit)
                dr_flag <= 1'b0;
            irq <= {dr_flag & int_enable[7] & int_map[7],
                    dr_flag & int_enable[7] & ~int_map[7]};
        end
    end

    assign int_source = {dr_flag, 7'b0};
    assign interrupt  = irq;
`else
    logic unused_sample_valid;
    assign unused_sample_valid = sample_valid;
    assign int_source = 8'h00;
    assign interrupt  = 2'b00;
`endif

    // The byte for the next read slot is chosen at the rise closing the previous byte.
    always_comb begin
        rd_addr = (state == S_CMD) ? byte_in[5:0] : addr_next;
        rd_byte = 8'h00;
        case (rd_addr)
            6'h00: rd_byte = DEVID;
            6'h2C: rd_byte = bw_rate;
            6'h2D: rd_byte = power_ctl;
            6'h2E: rd_byte = int_enable;
            6'h2F: rd_byte = int_map;
            6'h30: rd_byte = int_source;
            6'h31: rd_byte = data_format;
            6'h32: rd_byte = shad_x[7:0];
            6'h33: rd_byte = shad_x[15:8];
            6'h34: rd_byte = shad_y[7:0];
            6'h35: rd_byte = shad_y[15:8];
            6'h36: rd_byte = shad_z[7:0];
            6'h37: rd_byte = shad_z[15:8];
            default: rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        wr_ok = 1'b0;
        case (addr)
            6'h2C, 6'h2D, 6'h2E, 6'h2F, 6'h31: wr_ok = 1'b1;
            default: wr_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            bit_cnt     <= 3'd0;
            shift_in    <= 8'h00;
            shift_out   <= 8'h00;
            addr        <= 6'd0;
            rnw         <= 1'b0;
            mb          <= 1'b0;
            sdo         <= 1'b0;
            wr_strobe   <= 1'b0;
            wr_addr     <= 6'd0;
            wr_data     <= 8'h00;
            bw_rate     <= BW_RATE_RST;
            power_ctl   <= 8'h00;
            int_enable  <= 8'h00;
            int_map     <= 8'h00;
            data_format <= 8'h00;
            shad_x      <= 16'h0000;
            shad_y      <= 16'h0000;
            shad_z      <= 16'h0000;
        end else begin
            wr_strobe <= 1'b0;
            if (csn_rise) begin
                state   <= S_IDLE;
                sdo     <= 1'b0;
                bit_cnt <= 3'd0;
            end else if (csn_fall) begin
                state   <= S_CMD;
                sdo     <= 1'b0;
                bit_cnt <= 3'd0;
                shad_x  <= data_x;
                shad_y  <= data_y;
                shad_z  <= data_z;
            end else if (state != S_IDLE) begin
                if (sclk_rise) begin
                    shift_in <= byte_in;
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (byte_done) begin
                        shift_out <= rd_byte;
                        if (state == S_CMD) begin
                            rnw   <= byte_in[7];
                            mb    <= byte_in[6];
                            addr  <= byte_in[5:0];
                            state <= S_DATA;
                        end else begin
                            addr <= addr_next;
                            if (!rnw && wr_ok) begin
                                wr_strobe <= 1'b1;
                                wr_addr   <= addr;
                                wr_data   <= byte_in;
                                case (addr)
                                    6'h2C: bw_rate     <= byte_in;
                                    6'h2D: power_ctl   <= byte_in;
                                    6'h2E: int_enable  <= byte_in;
                                    6'h2F: int_map     <= byte_in;
                                    default: data_format <= byte_in;
                                endcase
                            end
                        end
                    end
                end else if (sclk_fall && state == S_DATA && rnw) begin
                    sdo       <= shift_out[7];
                    shift_out <= {shift_out[6:0], 1'b0};
                end
            end
        end
    end

    assign spi.spi_sdo    = sdo;
    assign spi.spi_sdo_oe = (state == S_DATA) && rnw;
endmodule

// File: tb/tb_adxl_spi_responder.sv
// Self-checking bench for adxl_spi_responder: mode-3 SPI master, read/write scoreboards.
module tb_adxl_spi_responder;
    localparam int HALF = 80;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_x, data_y, data_z;
    logic        sample_valid;
    logic        wr_strobe;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [1:0]  interrupt;

    always #5 clk = ~clk;

    adxl_spi_if spi();

    adxl_spi_responder dut (
        .clk          (clk),
        .rst          (rst),
        .spi          (spi),
        .data_x       (data_x),
        .data_y       (data_y),
        .data_z       (data_z),
        .sample_valid (sample_valid),
        .wr_strobe    (wr_strobe),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .interrupt    (interrupt)
    );

    typedef struct {
        string       name;
        logic [7:0]  cmd;
        int          n;
        logic [47:0] tx;   // byte i at [8*i +: 8]
        logic [47:0] ex;
        int          chg;  // data byte index after which samples change, -1 none
    } vec_t;

    vec_t        vecs[$];
    logic [7:0]  rd_q[$];
    logic [13:0] wr_q[$];
    logic [13:0] wexp;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got nothing expected an entry", nm);
    endtask

    function automatic bit is_rw(input logic [5:0] a);
        return a == 6'h2C || a == 6'h2D || a == 6'h2E || a == 6'h2F || a == 6'h31;
    endfunction

    task automatic add(input string nm, input logic [7:0] c, input int n,
                       input logic [47:0] tx, input logic [47:0] ex, input int chg);
        vec_t v;
        v.name = nm; v.cmd = c; v.n = n; v.tx = tx; v.ex = ex; v.chg = chg;
        vecs.push_back(v);
    endtask

    task automatic pulse_sv();
        @(negedge clk) sample_valid = 1'b1;
        @(negedge clk) sample_valid = 1'b0;
    endtask

    // Master drives SDI on SCLK fall and samples SDO just before the rise.
    task automatic xbyte(input string nm, input logic [7:0] tx, input int nbits,
                         input logic exp_oe, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi.spi_clk = 1'b0;
            spi.spi_sdi = tx[i];
            #HALF;
            rx[i] = spi.spi_sdo;
            if (i == 8 - nbits)
                check({nm, " oe"}, {15'd0, spi.spi_sdo_oe}, {15'd0, exp_oe});
            spi.spi_clk = 1'b1;
            #HALF;
        end
    endtask

    task automatic xfer(input string nm, input logic [7:0] cmd, input int n, input logic [47:0] tx,
                        input logic [47:0] ex, input int chg, input int last_bits);
        logic [7:0] rx;
        logic [5:0] a;
        int         nb;
        a = cmd[5:0];
        for (int i = 0; i < n; i++) begin
            nb = (i == n - 1) ? last_bits : 8;
            if (cmd[7]) begin
                if (nb == 8) rd_q.push_back(ex[8*i +: 8]);
            end else if (nb == 8 && is_rw(a)) begin
                wr_q.push_back({a, tx[8*i +: 8]});
            end
            if (cmd[6]) a = a + 6'd1;
        end
        spi.spi_csn = 1'b0;
        #HALF;
        xbyte({nm, " cmd"}, cmd, 8, 1'b0, rx);
        for (int i = 0; i < n; i++) begin
            nb = (i == n - 1) ? last_bits : 8;
            xbyte($sformatf("%s b%0d", nm, i), tx[8*i +: 8], nb, cmd[7], rx);
            if (cmd[7] && nb == 8) begin
                if (rd_q.size() == 0) fail_now({nm, " rd_q"});
                else check($sformatf("%s byte%0d", nm, i), {8'h00, rx}, {8'h00, rd_q.pop_front()});
            end
            if (i == chg) begin
                data_x = 16'h1234; data_y = 16'h5678; data_z = 16'h9ABC;
                pulse_sv();
            end
        end
        #HALF;
        spi.spi_csn = 1'b1;
        repeat (12) @(negedge clk);
        check({nm, " idle sdo"}, {15'd0, spi.spi_sdo}, 16'd0);
        check({nm, " idle oe"}, {15'd0, spi.spi_sdo_oe}, 16'd0);
    endtask

    always @(negedge clk) begin
        if (wr_strobe) begin
            if (wr_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wr_strobe unexpected: got addr %h data %h expected none", wr_addr, wr_data);
            end else begin
                wexp = wr_q.pop_front();
                check("wr_strobe addr/data", {2'b00, wr_addr, wr_data}, {2'b00, wexp});
            end
        end
    end

    initial begin
        logic [7:0] rx;
        rst = 1'b1;
        spi.spi_clk = 1'b1; spi.spi_csn = 1'b1; spi.spi_sdi = 1'b0;
        data_x = 16'hFF38; data_y = 16'h0064; data_z = 16'h00FA;
        sample_valid = 1'b0;

        add("rd DEVID",      8'h80, 1, 48'h0,    48'hE5,           -1);
        add("wr POWER_CTL",  8'h2D, 1, 48'h08,   48'h0,            -1);
        add("rd POWER_CTL",  8'hAD, 1, 48'h0,    48'h08,           -1);
        add("rd BW_RATE",    8'hAC, 1, 48'h0,    48'h0A,           -1);
        add("rd DATA_FMT",   8'hB1, 1, 48'h0,    48'h00,           -1);
        add("burst xyz",     8'hF2, 6, 48'h0,    48'h00FA0064FF38, -1);
        add("burst snap",    8'hF2, 6, 48'h0,    48'h00FA0064FF38,  1);
        add("rd new x",      8'hF2, 2, 48'h0,    48'h1234,         -1);
        add("burst wrap",    8'hFF, 3, 48'h0,    48'h00E500,       -1);
        add("no-MB repeat",  8'h80, 2, 48'h0,    48'hE5E5,         -1);
        add("wr read-only",  8'h00, 1, 48'h55,   48'h0,            -1);
        add("rd DEVID again",8'h80, 1, 48'h0,    48'hE5,           -1);
        add("MB wr 2E/2F",   8'h6E, 2, 48'h0080, 48'h0,            -1);
        add("MB rd 2E/2F",   8'hEE, 2, 48'h0,    48'h0080,         -1);
        add("rd unimpl",     8'h90, 1, 48'h0,    48'h00,           -1);

        repeat (4) @(negedge clk);
        check("reset sdo", {15'd0, spi.spi_sdo}, 16'd0);
        check("reset oe", {15'd0, spi.spi_sdo_oe}, 16'd0);
        check("reset wr_strobe", {15'd0, wr_strobe}, 16'd0);
        check("reset interrupt", {14'd0, interrupt}, 16'd0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        foreach (vecs[k])
            xfer(vecs[k].name, vecs[k].cmd, vecs[k].n, vecs[k].tx, vecs[k].ex, vecs[k].chg, 8);

        // CSN raised mid data byte: the partial write must be discarded
        xfer("partial wr", 8'h2D, 1, 48'hFF, 48'h0, -1, 4);
        xfer("rd after partial", 8'hAD, 1, 48'h0, 48'h08, -1, 8);

`ifdef ADXL_INT_EN
        pulse_sv();
        repeat (5) @(negedge clk);
        check("int1 after sample", {14'd0, interrupt}, 16'd1);
        xfer("rd INT_SOURCE", 8'hB0, 1, 48'h0, 48'h80, -1, 8);
        check("int kept after 0x30 rd", {14'd0, interrupt}, 16'd1);
        xfer("burst clears", 8'hF2, 6, 48'h0, {data_z, data_y, data_x}, -1, 8);
        check("int after burst", {14'd0, interrupt}, 16'd0);
        xfer("wr INT_MAP", 8'h2F, 1, 48'h80, 48'h0, -1, 8);
        pulse_sv();
        repeat (5) @(negedge clk);
        check("int2 mapped", {14'd0, interrupt}, 16'd2);
`else
        pulse_sv();
        repeat (5) @(negedge clk);
        check("interrupt tied off", {14'd0, interrupt}, 16'd0);
        xfer("rd INT_SOURCE", 8'hB0, 1, 48'h0, 48'h00, -1, 8);
`endif

        // Reset mid-transaction: bus ignored until a fresh CSN fall
        spi.spi_csn = 1'b0;
        #HALF;
        xbyte("rst cmd", 8'h2D, 8, 1'b0, rx);
        xbyte("rst pre", 8'hFF, 4, 1'b0, rx);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst oe", {15'd0, spi.spi_sdo_oe}, 16'd0);
        check("rst interrupt", {14'd0, interrupt}, 16'd0);
        rst = 1'b0;
        xbyte("rst post0", 8'hFF, 8, 1'b0, rx);
        xbyte("rst post1", 8'hFF, 8, 1'b0, rx);
        #HALF;
        spi.spi_csn = 1'b1;
        repeat (12) @(negedge clk);
        xfer("rd POWER_CTL rst", 8'hAD, 1, 48'h0, 48'h00, -1, 8);
        xfer("rd BW_RATE rst",   8'hAC, 1, 48'h0, 48'h0A, -1, 8);
        xfer("rd INT_EN rst",    8'hAE, 1, 48'h0, 48'h00, -1, 8);

        check("pending strobes", 16'(wr_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/adxl_spi_responder.md
# adxl_spi_responder

- Behavioural SPI slave that emulates the ADXL345 accelerometer's 4-wire SPI port (mode 3) on the far end of the board's G-sensor bus.
- Lets `spi_control` and everything downstream of it (display digits, VGA readout, servo PWM) be simulated and FPGA-looped without the physical sensor.
- Fed with 16-bit X/Y/Z samples from a testbench or pattern generator; answers register reads and writes exactly as the sensor does for the implemented register subset.

## Interface
Parameters:
- `DEVID`, 8'hE5, value returned at address 0x00.
- `BW_RATE_RST`, 8'h0A, reset value of register 0x2C.

Ports:
- `clk` in 1: system clock; must be ≥8× SCLK frequency.
- `rst` in 1: reset, asynchronous, active-high.
- `spi_clk` in 1: SCLK from master; idles high.
- `spi_csn` in 1: chip select, active-low.
- `spi_sdi` in 1: MOSI.
- `spi_sdo` out 1: MISO; 0 when idle.
- `spi_sdo_oe` out 1: high only in DATA state of a read transaction.
- `data_x`, `data_y`, `data_z` in 16 each: two's-complement samples.
- `sample_valid` in 1: one-cycle pulse when new samples are present.
- `wr_strobe` out 1: one-cycle pulse per accepted register write.
- `wr_addr` out 6: address of that write.
- `wr_data` out 8: data of that write.
- `interrupt` out 2: [0]=INT1, [1]=INT2.

## Operation
- **Synchronisation:** `spi_clk`, `spi_csn` and `spi_sdi` each pass through 2-FF synchronisers. Rise/fall of `spi_clk` and `spi_csn` are edge-detected on the synchronised copies.
- **FSM:** IDLE → CMD on CSN fall; CMD → DATA after the 8th SCLK rise; DATA loops per byte; any state → IDLE on CSN rise, which discards any partial byte.
- **Bit order and edges:** MSB first. SDI is sampled on SCLK rise; SDO is updated on SCLK fall. A 3-bit counter tracks bits within the byte.
- **Command byte:** bit7 = R/nW, bit6 = MB (multi-byte), bits5:0 = address.
- **Addressing:**
  - MB=1: address increments after each data byte and wraps 0x3F → 0x00.
  - MB=0: address stays fixed for every byte of the transaction.
- **Snapshot:** on CSN fall, `data_x`/`data_y`/`data_z` are copied into shadow registers. All reads in that transaction return the shadow values, so a burst is coherent.
- **Register map:**
  - 0x00: DEVID, read-only.
  - 0x2C: BW_RATE, read/write, reset `BW_RATE_RST`.
  - 0x2D: POWER_CTL, read/write, reset 0.
  - 0x2E: INT_ENABLE, read/write, reset 0.
  - 0x2F: INT_MAP, read/write, reset 0.
  - 0x30: INT_SOURCE, read-only.
  - 0x31: DATA_FORMAT, read/write, reset 0.
  - 0x32–0x37: X0, X1, Y0, Y1, Z0, Z1 (low byte first), read-only.
  - All other addresses read 0x00; writes to them are ignored.
- **Writes:** a write to a read/write address commits on the 8th SCLK rise of its data byte. In the same cycle, `wr_strobe` pulses with `wr_addr`/`wr_data`. Writes to read-only or unimplemented addresses produce no strobe.
- **Reads:** the byte is loaded into the shift register on the SCLK rise that completes the previous byte (command or data). Its MSB drives SDO from the following SCLK fall.
- **Reset values:** all outputs 0; state IDLE; registers at reset values; shadows 0.

## Timing
- SDI is captured 3 `clk` cycles after the SCLK rising edge (2-FF synchroniser plus edge register).
- SDO changes ≤3 `clk` cycles after the SCLK falling edge, well inside the half-period at ≥8× oversampling.
- `wr_strobe` asserts 3 `clk` cycles after the 8th SCLK rise of the data byte.
- CSN rise returns the block to IDLE 3 cycles later; `spi_sdo` and `spi_sdo_oe` are 0 from that cycle.
- `rst` during a transaction forces IDLE immediately. The block then ignores the bus until the next CSN fall seen with `rst` low.
- CSN fall and `sample_valid` in the same cycle: the snapshot takes the new `data_*` values.

## Configuration
- **`ADXL_INT_EN` defined:**
  - DATA_READY flag sets on `sample_valid` and reads as INT_SOURCE bit7.
  - It clears on the CSN rise ending any read transaction that returned at least one byte from 0x32–0x37; a set in the same cycle wins.
  - INT1 = flag & INT_ENABLE[7] & ~INT_MAP[7]; INT2 = flag & INT_ENABLE[7] & INT_MAP[7]. Both are registered.
- **Undefined:** `interrupt` is tied to 2'b00 and INT_SOURCE reads 0x00. INT_ENABLE and INT_MAP remain writable.

## Test plan
- Read 0x00 (command 0x80, one data byte) → SDO returns 0xE5; `spi_sdo_oe` high only during the data byte.
- Write 0x2D = 0x08, then read 0x2D → `wr_strobe` once with `wr_addr`=0x2D and `wr_data`=0x08; read returns 0x08.
- Set `data_x`=16'hFF38, `data_y`=16'h0064, `data_z`=16'h00FA, then MB read of 6 bytes from 0x32 (command 0xF2) → 38 FF 64 00 FA 00.
- During a 6-byte burst, change `data_*` with a `sample_valid` pulse after byte 2 → all 6 bytes still come from the CSN-fall snapshot.
- MB read of 3 bytes from 0x3F → bytes 0x00, 0xE5, 0x00 (address wraps to 0x00); CSN raised after 4 bits of a write byte → no `wr_strobe`.
- With `ADXL_INT_EN`, INT_ENABLE=0x80 and INT_MAP=0x00, pulse `sample_valid` → `interrupt`=2'b01; after a burst read from 0x32 ends, `interrupt`=2'b00.
